// File: rtl/pixel_clk_div_if.sv
// Signal bundle between pixel_clk_div and its controller: run control, divisor load, strobes.
// The CLK and RST signals are not part of the bundle; they stay plain ports on the module.
interface pixel_clk_div_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             EN;
  logic             SYNC;
  logic [WIDTH-1:0] DIV_IN;
  logic             DIV_LOAD;
  logic             DIV_BUSY;
  logic             PIXEN;
  logic             PIXSQ;
  logic [WIDTH-1:0] CNT;

  modport master (
    output EN, SYNC, DIV_IN, DIV_LOAD,
    input  DIV_BUSY, PIXEN, PIXSQ, CNT
  );

  modport slave (
    input  EN, SYNC, DIV_IN, DIV_LOAD,
    output DIV_BUSY, PIXEN, PIXSQ, CNT
  );

endinterface

// File: rtl/pixel_clk_div.sv
// Pixel clock-enable generator: run-time divisor applied at period boundaries, SYNC restart.
// Define PIXDIV_SQUARE_EN to build the phase-aligned square-wave output PIXSQ.
module pixel_clk_div #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic           CLK,
  input  logic           RST,
  pixel_clk_div_if.slave bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_v_q, pend_v_d;
  logic             pixen_q, pixen_d;
  logic [WIDTH-1:0] n_q;
  logic             wrap;

  // A divisor of 0 behaves like 1; >= also catches a counter left beyond a shrunken divisor.
  assign n_q  = (div_act_q == '0) ? WIDTH'(1) : div_act_q;
  assign wrap = (cnt_q >= (n_q - WIDTH'(1)));

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_v_d   = pend_v_q;
    pixen_d    = 1'b0;
    if (bus.SYNC) begin
      cnt_d    = '0;
      pend_v_d = 1'b0;
      if (bus.DIV_LOAD) begin
        div_act_d = bus.DIV_IN;
      end else if (pend_v_q) begin
        div_act_d = div_pend_q;
      end
    end else begin
      if (bus.EN) begin
        if (wrap) begin
          cnt_d   = '0;
          pixen_d = 1'b1;
          if (pend_v_q) begin
            div_act_d = div_pend_q;
            pend_v_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      // A load on a wrap edge stays pending for the following period.
      if (bus.DIV_LOAD) begin
        div_pend_d = bus.DIV_IN;
        pend_v_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q      <= '0;
      div_act_q  <= WIDTH'(DEFAULT_DIV);
      div_pend_q <= '0;
      pend_v_q   <= 1'b0;
      pixen_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_v_q   <= pend_v_d;
      pixen_q    <= pixen_d;
    end
  end

`ifdef PIXDIV_SQUARE_EN
  logic [WIDTH-1:0] n_d;
  logic             pixsq_q, pixsq_d;

  // Compare against the divisor that governs the period the new count belongs to.
  always_comb begin
    n_d     = (div_act_d == '0) ? WIDTH'(1) : div_act_d;
    pixsq_d = pixsq_q;
    if (bus.SYNC || bus.EN) begin
      pixsq_d = (cnt_d < (n_d >> 1));
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pixsq_q <= 1'b0;
    end else begin
      pixsq_q <= pixsq_d;
    end
  end

  assign bus.PIXSQ = pixsq_q;
`else
  assign bus.PIXSQ = 1'b0;
`endif

  assign bus.CNT      = cnt_q;
  assign bus.PIXEN    = pixen_q;
  assign bus.DIV_BUSY = pend_v_q;

endmodule
